// File: rtl/msg_event_collector.sv
// Multi-channel message event collector: round-robin arbitration, per-type counters,
// severity-filtered log FIFO and sticky stop/exit requests. Optional macro: MSG_TIMESTAMP_EN.
module msg_event_collector #(
    parameter int NUM_CH     = 4,
    parameter int CODE_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 32,
    parameter int ERR_LIMIT  = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef MSG_TIMESTAMP_EN
    localparam int LOG_W     = TS_W + CH_W + 6 + CODE_W
`else
    // TS_W only sizes the timestamp field, which is absent in this build
    localparam int LOG_W     = CH_W + 6 + CODE_W + (0 * TS_W)
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [2*NUM_CH-1:0]      ch_type,
    input  logic [2*NUM_CH-1:0]      ch_svrt,
    input  logic [2*NUM_CH-1:0]      ch_act,
    input  logic [CODE_W*NUM_CH-1:0] ch_code,
    input  logic [1:0]               svrt_thold,
    input  logic                     clr,
    output logic                     log_valid,
    input  logic                     log_ready,
    output logic [LOG_W-1:0]         log_data,
    output logic [CNT_W-1:0]         cnt_info,
    output logic [CNT_W-1:0]         cnt_warn,
    output logic [CNT_W-1:0]         cnt_error,
    output logic [CNT_W-1:0]         cnt_fatal,
    output logic [CNT_W-1:0]         filt_cnt,
    output logic                     stop_req,
    output logic                     exit_req
);

    localparam int AW = $clog2(FIFO_DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CH_W-1:0]   ptr_r;
    logic [CH_W-1:0]   cand_s;
    logic [CH_W-1:0]   gnt_idx_s;
    logic              gnt_any_s;
    logic              hit_s;
    logic              full_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [1:0]        sel_type_s;
    logic [1:0]        sel_svrt_s;
    logic [1:0]        sel_act_s;
    logic [CODE_W-1:0] sel_code_s;
    logic [LOG_W-1:0]  entry_s;

    logic [LOG_W-1:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic [AW:0]       count_nxt_s;
    logic              log_valid_r;

    logic [CNT_W-1:0]  cnt_info_r, cnt_warn_r, cnt_error_r, cnt_fatal_r, filt_cnt_r;
    logic [CNT_W-1:0]  info_base_s, warn_base_s, error_base_s, fatal_base_s, filt_base_s;
    logic [CNT_W-1:0]  info_nxt_s, warn_nxt_s, error_nxt_s, fatal_nxt_s, filt_nxt_s;
    logic [CNT_W:0]    err_sum_cur_s, err_sum_nxt_s;
    logic              lim_hit_s;
    logic              stop_r, exit_r, stop_nxt_s, exit_nxt_s;

`ifdef MSG_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_r;
`endif

    // Round-robin search: first valid channel at or after the pointer, wrapping
    always_comb begin
        cand_s    = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        hit_s     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s    = CH_W'((int'(ptr_r) + k) % NUM_CH);
            hit_s     = !gnt_any_s && ch_valid[cand_s];
            gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
            gnt_any_s = gnt_any_s | hit_s;
        end
    end

    assign full_s   = (count_r == (AW+1)'(FIFO_DEPTH));
    assign accept_s = gnt_any_s && !full_s;
    assign ch_ready = accept_s ? (NUM_CH'(1) << gnt_idx_s) : '0;

    assign sel_type_s = ch_type[2*gnt_idx_s +: 2];
    assign sel_svrt_s = ch_svrt[2*gnt_idx_s +: 2];
    assign sel_act_s  = ch_act[2*gnt_idx_s +: 2];
    assign sel_code_s = ch_code[CODE_W*gnt_idx_s +: CODE_W];

`ifdef MSG_TIMESTAMP_EN
    assign entry_s = {ts_r, gnt_idx_s, sel_type_s, sel_svrt_s, sel_act_s, sel_code_s};
`else
    assign entry_s = {gnt_idx_s, sel_type_s, sel_svrt_s, sel_act_s, sel_code_s};
`endif

    assign push_s = accept_s && (sel_svrt_s >= svrt_thold);
    assign pop_s  = (count_r != '0) && log_ready;

    // FIFO occupancy next-state
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // Counter and sticky next-state; clr clears the base, a same-cycle event still counts
    always_comb begin
        info_base_s  = clr ? '0 : cnt_info_r;
        warn_base_s  = clr ? '0 : cnt_warn_r;
        error_base_s = clr ? '0 : cnt_error_r;
        fatal_base_s = clr ? '0 : cnt_fatal_r;
        filt_base_s  = clr ? '0 : filt_cnt_r;
        info_nxt_s   = (accept_s && sel_type_s == 2'd0) ? sat_inc(info_base_s)  : info_base_s;
        warn_nxt_s   = (accept_s && sel_type_s == 2'd1) ? sat_inc(warn_base_s)  : warn_base_s;
        error_nxt_s  = (accept_s && sel_type_s == 2'd2) ? sat_inc(error_base_s) : error_base_s;
        fatal_nxt_s  = (accept_s && sel_type_s == 2'd3) ? sat_inc(fatal_base_s) : fatal_base_s;
        filt_nxt_s   = (accept_s && !push_s) ? sat_inc(filt_base_s) : filt_base_s;
        err_sum_cur_s = {1'b0, error_base_s} + {1'b0, fatal_base_s};
        err_sum_nxt_s = {1'b0, error_nxt_s} + {1'b0, fatal_nxt_s};
        lim_hit_s  = (ERR_LIMIT != 0) && (int'(err_sum_nxt_s) >= ERR_LIMIT)
                     && (int'(err_sum_cur_s) < ERR_LIMIT);
        stop_nxt_s = (clr ? 1'b0 : stop_r) | (accept_s && sel_act_s == 2'd1) | lim_hit_s;
        exit_nxt_s = (clr ? 1'b0 : exit_r) | (accept_s && (sel_act_s[1] || sel_type_s == 2'd3));
    end

    // Arbitration pointer, FIFO control, counters and stickies
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            log_valid_r <= 1'b0;
            cnt_info_r  <= '0;
            cnt_warn_r  <= '0;
            cnt_error_r <= '0;
            cnt_fatal_r <= '0;
            filt_cnt_r  <= '0;
            stop_r      <= 1'b0;
            exit_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                ptr_r <= (gnt_idx_s == CH_W'(NUM_CH-1)) ? '0 : gnt_idx_s + {{(CH_W-1){1'b0}}, 1'b1};
            end else begin
                ptr_r <= ptr_r;
            end
            wr_ptr_r    <= push_s ? wr_ptr_r + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_r;
            rd_ptr_r    <= pop_s  ? rd_ptr_r + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_r;
            count_r     <= count_nxt_s;
            log_valid_r <= (count_nxt_s != '0);
            cnt_info_r  <= info_nxt_s;
            cnt_warn_r  <= warn_nxt_s;
            cnt_error_r <= error_nxt_s;
            cnt_fatal_r <= fatal_nxt_s;
            filt_cnt_r  <= filt_nxt_s;
            stop_r      <= stop_nxt_s;
            exit_r      <= exit_nxt_s;
        end
    end

    // Log storage; contents behind an empty FIFO are never visible
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

`ifdef MSG_TIMESTAMP_EN
    // Free-running cycle timestamp
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
        end
    end
`endif

    assign log_valid = log_valid_r;
    assign log_data  = log_valid_r ? mem_r[rd_ptr_r] : '0;
    assign cnt_info  = cnt_info_r;
    assign cnt_warn  = cnt_warn_r;
    assign cnt_error = cnt_error_r;
    assign cnt_fatal = cnt_fatal_r;
    assign filt_cnt  = filt_cnt_r;
    assign stop_req  = stop_r;
    assign exit_req  = exit_r;

endmodule

// File: tb/tb_msg_event_collector.sv
// Directed self-checking bench for msg_event_collector (NUM_CH=4, FIFO_DEPTH=16, CNT_W=8, ERR_LIMIT=3).
module tb_msg_event_collector;

    localparam int CH_W = 2;
`ifdef MSG_TIMESTAMP_EN
    localparam int LOG_W = 32 + CH_W + 6 + 16;
`else
    localparam int LOG_W = CH_W + 6 + 16;
`endif

    logic             clk;
    logic             rst;
    logic [3:0]       ch_valid;
    logic [3:0]       ch_ready;
    logic [7:0]       ch_type;
    logic [7:0]       ch_svrt;
    logic [7:0]       ch_act;
    logic [63:0]      ch_code;
    logic [1:0]       svrt_thold;
    logic             clr;
    logic             log_valid;
    logic             log_ready;
    logic [LOG_W-1:0] log_data;
    logic [7:0]       cnt_info, cnt_warn, cnt_error, cnt_fatal, filt_cnt;
    logic             stop_req;
    logic             exit_req;

    int err_cnt = 0;
    int chk_cnt = 0;

    msg_event_collector #(
        .NUM_CH(4), .CODE_W(16), .FIFO_DEPTH(16), .CNT_W(8), .TS_W(32), .ERR_LIMIT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_type(ch_type), .ch_svrt(ch_svrt), .ch_act(ch_act), .ch_code(ch_code),
        .svrt_thold(svrt_thold), .clr(clr),
        .log_valid(log_valid), .log_ready(log_ready), .log_data(log_data),
        .cnt_info(cnt_info), .cnt_warn(cnt_warn), .cnt_error(cnt_error), .cnt_fatal(cnt_fatal),
        .filt_cnt(filt_cnt), .stop_req(stop_req), .exit_req(exit_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic v, input logic [1:0] t, input logic [1:0] s,
                          input logic [1:0] a, input logic [15:0] c);
        ch_valid[i]       = v;
        ch_type[2*i +: 2] = t;
        ch_svrt[2*i +: 2] = s;
        ch_act[2*i +: 2]  = a;
        ch_code[16*i +: 16] = c;
    endtask

    // Low 24 bits of a log entry: {ch, type, svrt, act, code}
    function automatic logic [63:0] ent(input int ch, input int t, input int s, input int a, input int c);
        return (64'(ch) << 22) | (64'(t) << 20) | (64'(s) << 18) | (64'(a) << 16) | 64'(c & 16'hFFFF);
    endfunction

    initial begin
        rst = 1'b1; clr = 1'b0; log_ready = 1'b0; svrt_thold = 2'd0;
        ch_valid = '0; ch_type = '0; ch_svrt = '0; ch_act = '0; ch_code = '0;
        tick; tick;
        rst = 1'b0;
        #1;
        check("rst_log_valid", 64'(log_valid), 64'd0);
        check("rst_log_data", 64'(log_data), 64'd0);
        check("rst_counts", 64'({cnt_info, cnt_warn, cnt_error, cnt_fatal, filt_cnt}), 64'd0);
        check("rst_sticky", 64'({stop_req, exit_req}), 64'd0);
        check("rst_ready", 64'(ch_ready), 64'd0);

        // Round-robin: all four channels valid, grants in order 0..3
        for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 2'd0, 2'd0, 2'd0, 16'(16'hA0 + i));
        for (int g = 0; g < 4; g++) begin
            #1;
            check("rr_grant", 64'(ch_ready), 64'd1 << g);
            tick;
            ch_valid[g] = 1'b0;
            if (g == 0) check("rr_valid_lat1", 64'(log_valid), 64'd1);
        end
        check("rr_cnt_info", 64'(cnt_info), 64'd4);
        log_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rr_drain", 64'(log_data[23:0]), ent(i, 0, 0, 0, 16'hA0 + i));
            tick;
        end
        log_ready = 1'b0;
        check("rr_empty", 64'(log_valid), 64'd0);

        // Fill to full from ch2, one pop gives one more accept, order preserved
        for (int n = 0; n < 16; n++) begin
            set_ch(2, 1'b1, 2'd0, 2'd0, 2'd0, 16'(n));
            #1;
            check("fill_ready", 64'(ch_ready), 64'h4);
            tick;
        end
        set_ch(2, 1'b1, 2'd0, 2'd0, 2'd0, 16'd16);
        #1;
        check("full_ready", 64'(ch_ready), 64'd0);
        check("full_head", 64'(log_data[15:0]), 64'd0);
        tick;
        check("full_hold", 64'(log_data[15:0]), 64'd0);
        log_ready = 1'b1;
        #1;
        check("full_no_passthru", 64'(ch_ready), 64'd0);
        tick;
        log_ready = 1'b0;
        #1;
        check("after_pop_ready", 64'(ch_ready), 64'h4);
        tick;
        ch_valid = '0;
        set_ch(2, 1'b1, 2'd0, 2'd0, 2'd0, 16'd17);
        #1;
        check("refull_ready", 64'(ch_ready), 64'd0);
        ch_valid = '0;
        log_ready = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            check("order", 64'(log_data[23:0]), ent(2, 0, 0, 0, n));
            tick;
        end
        log_ready = 1'b0;
        check("order_empty", 64'(log_valid), 64'd0);
        check("fill_cnt_info", 64'(cnt_info), 64'd21);

        // Below-threshold event is counted but not logged
        clr = 1'b1; tick; clr = 1'b0;
        svrt_thold = 2'd2;
        set_ch(1, 1'b1, 2'd1, 2'd0, 2'd0, 16'h1234);
        #1;
        check("filt_ready", 64'(ch_ready), 64'h2);
        tick;
        ch_valid = '0;
        check("filt_cnt_warn", 64'(cnt_warn), 64'd1);
        check("filt_filt_cnt", 64'(filt_cnt), 64'd1);
        check("filt_no_log", 64'(log_valid), 64'd0);
        check("filt_cnt_info", 64'(cnt_info), 64'd0);

        // Actions: STOP then FATAL, then clr
        set_ch(0, 1'b1, 2'd2, 2'd2, 2'd1, 16'h000E);
        tick;
        ch_valid = '0;
        check("act_stop", 64'({stop_req, exit_req}), 64'b10);
        check("act_logged", 64'(log_valid), 64'd1);
        set_ch(3, 1'b1, 2'd3, 2'd0, 2'd0, 16'h000F);
        tick;
        ch_valid = '0;
        check("act_exit", 64'({stop_req, exit_req}), 64'b11);
        check("act_cnts", 64'({cnt_error, cnt_fatal, filt_cnt}), {40'd0, 8'd1, 8'd1, 8'd2});
        clr = 1'b1; tick; clr = 1'b0;
        check("clr_sticky", 64'({stop_req, exit_req}), 64'd0);
        check("clr_cnts", 64'({cnt_error, cnt_fatal, filt_cnt, cnt_warn}), 64'd0);
        check("clr_keeps_fifo", 64'(log_data[23:0]), ent(0, 2, 2, 1, 16'h000E));
        log_ready = 1'b1; tick; log_ready = 1'b0;
        check("act_drained", 64'(log_valid), 64'd0);

        // clr with a same-cycle set: set wins, counter restarts at 1
        set_ch(0, 1'b1, 2'd2, 2'd0, 2'd1, 16'd0);
        clr = 1'b1; tick; clr = 1'b0;
        ch_valid = '0;
        check("clr_set_wins", 64'(stop_req), 64'd1);
        check("clr_cnt_one", 64'(cnt_error), 64'd1);
        clr = 1'b1; tick; clr = 1'b0;

        // ERR_LIMIT=3: stop after third ERROR
        set_ch(1, 1'b1, 2'd2, 2'd0, 2'd0, 16'd0);
        tick;
        check("lim_1", 64'({stop_req, cnt_error}), {55'd0, 1'b0, 8'd1});
        tick;
        check("lim_2", 64'({stop_req, cnt_error}), {55'd0, 1'b0, 8'd2});
        tick;
        ch_valid = '0;
        check("lim_3", 64'({stop_req, cnt_error}), {55'd0, 1'b1, 8'd3});

        // Saturation: 2^8+5 INFO events
        clr = 1'b1; tick; clr = 1'b0;
        set_ch(0, 1'b1, 2'd0, 2'd0, 2'd0, 16'd0);
        repeat (261) tick;
        ch_valid = '0;
        check("sat_info", 64'(cnt_info), 64'd255);
        check("sat_filt", 64'(filt_cnt), 64'd255);
        check("sat_no_stop", 64'(stop_req), 64'd0);

        // Reset mid-burst
        svrt_thold = 2'd0;
        set_ch(0, 1'b1, 2'd3, 2'd0, 2'd0, 16'd0);
        for (int i = 1; i < 4; i++) set_ch(i, 1'b1, 2'd0, 2'd0, 2'd0, 16'd0);
        repeat (4) tick;
        check("burst_exit", 64'(exit_req), 64'd1);
        check("burst_logged", 64'(log_valid), 64'd1);
        rst = 1'b1; tick; rst = 1'b0;
        check("mid_rst_valid", 64'(log_valid), 64'd0);
        check("mid_rst_data", 64'(log_data), 64'd0);
        check("mid_rst_state", 64'({exit_req, stop_req, cnt_info, cnt_fatal}), 64'd0);
        #1;
        check("mid_rst_ptr", 64'(ch_ready), 64'd1);
        ch_valid = '0;

        // Acceptances 10 and 25 cycles after reset
        repeat (10) tick;
        set_ch(0, 1'b1, 2'd0, 2'd1, 2'd0, 16'h0010);
        tick;
        ch_valid = '0;
        repeat (14) tick;
        set_ch(0, 1'b1, 2'd0, 2'd1, 2'd0, 16'h0019);
        tick;
        ch_valid = '0;
        check("ts_entry1", 64'(log_data[23:0]), ent(0, 0, 1, 0, 16'h0010));
`ifdef MSG_TIMESTAMP_EN
        check("ts_10", 64'(log_data[LOG_W-1 -: 32]), 64'd10);
`endif
        log_ready = 1'b1; tick; log_ready = 1'b0;
        check("ts_entry2", 64'(log_data[23:0]), ent(0, 0, 1, 0, 16'h0019));
`ifdef MSG_TIMESTAMP_EN
        check("ts_25", 64'(log_data[LOG_W-1 -: 32]), 64'd25);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
